response_monitor: RTL and testbench

- Synthesizable response monitor that sits on the output side of a DUT driven by the generated stimulus sequencer.
- The sequencer drives the DUT; this block observes DUT outputs and logs every value change with a cycle timestamp, like a hardware $monitor.
- Logged entries are buffered in a FIFO and drained by a show-ahead read handshake, for checking or readout by a host.

---
 rtl/response_monitor.sv | 102 ++++++++++
 tb/tb_response_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/response_monitor.sv
// Response monitor: logs each DUT output change with a timestamp into a show-ahead FIFO.
// Optional RESP_MONITOR_DROP_CNT_EN adds a saturating drop counter output.
module response_monitor #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_W-1:0]        dut_out,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
`ifdef RESP_MONITOR_DROP_CNT_EN
    output logic [7:0]               drop_cnt,
`endif
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [TS_W-1:0]   mem_t [DEPTH];

    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] prev;
    logic              first;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     cnt;
    logic              ovf;

    logic cap;
    logic pop;
    logic is_full;
    logic push;
    logic drop;

    assign cap     = en && (first || (dut_out != prev));
    assign pop     = rd_en && (cnt != '0);
    assign is_full = (cnt == CW'(DEPTH));
    // A pop on the same edge frees the slot the capture needs.
    assign push    = cap && (!is_full || pop);
    assign drop    = cap && is_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts    <= '0;
            prev  <= '0;
            first <= 1'b1;
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (en) begin
                ts    <= ts + 1'b1;
                prev  <= dut_out;
                first <= 1'b0;
            end else begin
                // Re-arm so the first sample after re-enable is always logged.
                first <= 1'b1;
            end
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
            if (drop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_d[wptr] <= dut_out;
            mem_t[wptr] <= ts;
        end
    end

`ifdef RESP_MONITOR_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (drop && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 1'b1;
    end
`endif

    assign rd_valid = (cnt != '0);
    assign rd_data  = rd_valid ? mem_d[rptr] : '0;
    assign rd_ts    = rd_valid ? mem_t[rptr] : '0;
    assign count    = cnt;
    assign full     = is_full;
    assign overflow = ovf;

endmodule

// File: tb/tb_response_monitor.sv
// Directed scoreboard bench for response_monitor (TS_W=16 and TS_W=4 instances).
module tb_response_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] dut_out;
    logic       rd_en;

    logic        v0, f0, o0;
    logic [7:0]  d0;
    logic [15:0] t0;
    logic [4:0]  c0;
    logic        v1, f1, o1;
    logic [7:0]  d1;
    logic [3:0]  t1;
    logic [4:0]  c1;
`ifdef RESP_MONITOR_DROP_CNT_EN
    logic [7:0]  dc0, dc1;
`endif

    int checks = 0;
    int errors = 0;

    logic [23:0] q0[$];
    logic [11:0] q1[$];
    logic [23:0] e0;
    logic [11:0] e1;

    always #5 clk = ~clk;

    response_monitor #(.DATA_W(8), .DEPTH(16), .TS_W(16)) u0 (
        .clk(clk), .rst(rst), .en(en), .dut_out(dut_out), .rd_en(rd_en),
        .rd_valid(v0), .rd_data(d0), .rd_ts(t0), .count(c0), .full(f0),
`ifdef RESP_MONITOR_DROP_CNT_EN
        .drop_cnt(dc0),
`endif
        .overflow(o0)
    );

    response_monitor #(.DATA_W(8), .DEPTH(16), .TS_W(4)) u1 (
        .clk(clk), .rst(rst), .en(en), .dut_out(dut_out), .rd_en(rd_en),
        .rd_valid(v1), .rd_data(d1), .rd_ts(t1), .count(c1), .full(f1),
`ifdef RESP_MONITOR_DROP_CNT_EN
        .drop_cnt(dc1),
`endif
        .overflow(o1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        rd_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain0(input string tag);
        while (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk({tag, "_valid"}, 32'(v0), 32'd1);
            chk({tag, "_data"}, 32'(d0), 32'(e0[23:16]));
            chk({tag, "_ts"}, 32'(t0), 32'(e0[15:0]));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        chk({tag, "_empty"}, 32'(v0), 32'd0);
        chk({tag, "_cnt0"}, 32'(c0), 32'd0);
    endtask

    task automatic drain1(input string tag);
        while (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk({tag, "_valid"}, 32'(v1), 32'd1);
            chk({tag, "_data"}, 32'(d1), 32'(e1[11:4]));
            chk({tag, "_ts"}, 32'(t1), 32'(e1[3:0]));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        chk({tag, "_empty"}, 32'(v1), 32'd0);
    endtask

    initial begin
        dut_out = 8'h00;
        do_reset();
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_count", 32'(c0), 32'd0);
        chk("rst_full", 32'(f0), 32'd0);
        chk("rst_ovf", 32'(o0), 32'd0);
        chk("rst_data", 32'(d0), 32'd0);
        chk("rst_ts", 32'(t0), 32'd0);

        // constant output logs once
        en = 1'b1;
        dut_out = 8'h00;
        q0.push_back({8'h00, 16'd0});
        tick();
        chk("t1_lat", 32'(v0), 32'd1);
        for (int i = 0; i < 9; i++) tick();
        chk("t1_count", 32'(c0), 32'd1);
        en = 1'b0;
        drain0("t1");

        // sparse changes
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            dut_out = (c < 3) ? 8'h01 : (c < 7) ? 8'h02 : 8'h05;
            if (c == 0) q0.push_back({8'h01, 16'd0});
            if (c == 3) q0.push_back({8'h02, 16'd3});
            if (c == 7) q0.push_back({8'h05, 16'd7});
            tick();
        end
        en = 1'b0;
        chk("t2_count", 32'(c0), 32'd3);
        drain0("t2");

        // overflow
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            dut_out = 8'h40 + 8'(c);
            if (c < 16) q0.push_back({dut_out, 16'(c)});
            tick();
            if (c == 15) begin
                chk("t3_full15", 32'(f0), 32'd1);
                chk("t3_ovf15", 32'(o0), 32'd0);
            end
            if (c == 16) chk("t3_ovf16", 32'(o0), 32'd1);
        end
        en = 1'b0;
        chk("t3_count", 32'(c0), 32'd16);
        chk("t3_full", 32'(f0), 32'd1);
`ifdef RESP_MONITOR_DROP_CNT_EN
        chk("t3_dropcnt", 32'(dc0), 32'd4);
`endif
        drain0("t3");
        chk("t3_sticky", 32'(o0), 32'd1);

        // capture and pop together while full
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            dut_out = 8'h60 + 8'(c);
            q0.push_back({dut_out, 16'(c)});
            tick();
        end
        chk("t4_full", 32'(f0), 32'd1);
        e0 = q0.pop_front();
        chk("t4_head", 32'(d0), 32'(e0[23:16]));
        dut_out = 8'h77;
        rd_en = 1'b1;
        q0.push_back({8'h77, 16'd16});
        tick();
        rd_en = 1'b0;
        en = 1'b0;
        chk("t4_count", 32'(c0), 32'd16);
        chk("t4_ovf", 32'(o0), 32'd0);
        drain0("t4");

        // re-enable with unchanged value
        do_reset();
        en = 1'b1;
        dut_out = 8'hAA;
        q0.push_back({8'hAA, 16'd0});
        for (int i = 0; i < 3; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_hold", 32'(c0), 32'd1);
        en = 1'b1;
        q0.push_back({8'hAA, 16'd3});
        tick();
        en = 1'b0;
        chk("t5_count", 32'(c0), 32'd2);
        drain0("t5");

        // timestamp wrap on the narrow instance, then reset with entries held
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 18; c++) begin
            dut_out = (c < 15) ? 8'h30 : (c < 17) ? 8'h31 : 8'h32;
            if (c == 0 || c == 15 || c == 17)
                q1.push_back({dut_out, 4'(c % 16)});
            tick();
        end
        en = 1'b0;
        chk("t6_count", 32'(c1), 32'd3);
        drain1("t6");
        en = 1'b1;
        dut_out = 8'h50;
        tick();
        dut_out = 8'h51;
        tick();
        en = 1'b0;
        chk("t6_two", 32'(c1), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_cnt", 32'(c1), 32'd0);
        chk("t6_rst_valid", 32'(v1), 32'd0);
        chk("t6_rst_ovf", 32'(o1), 32'd0);
        chk("t6_rst_u0", 32'(c0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
